vram_arbiter: RTL and testbench

Two-port arbiter that shares the single 16 KB video RAM between the ULA display fetch and the Z80 (contended page 0x4000–0x7FFF). Every access is a fixed two-cycle `clk14` slot. The ULA has priority, with a bounded-deferral fairness rule for the CPU. The CPU is stalled through `cpu_wait_n` until its slot completes. The block sits between the ULA's `va`/`vramdata` port, the CPU bus and the external SRAM.

---
 rtl/vram_arbiter.sv | 137 +++++++++++++
 tb/tb_vram_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// vram_arbiter: shares the 16 KB video RAM between ULA fetch and Z80, 2-cycle slots
// Revision 1.0
// ============================================================================
module vram_arbiter #(
  parameter int unsigned CPU_MAX_DEFER = 4
) (
  input  logic        clk14,
  input  logic        rst_n,
  input  logic        ula_req,
  input  logic [13:0] ula_va,
  output logic [7:0]  ula_dout,
  output logic        ula_ack,
  output logic        ula_ovf,
  input  logic [15:0] cpu_a,
  input  logic        cpu_mreq_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_wait_n,
  output logic [13:0] sram_a,
  output logic [7:0]  sram_din,
  input  logic [7:0]  sram_dout,
  output logic        sram_we_n
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_U_A  = 3'd1,
    S_U_D  = 3'd2,
    S_C_A  = 3'd3,
    S_C_D  = 3'd4
  } state_t;

  localparam logic [3:0] C_MAX_DEFER = 4'(CPU_MAX_DEFER);

  state_t      state_q, state_d;
  logic [13:0] ula_addr_q, ula_addr_d;
  logic        ula_pend_q, ula_pend_d;
  logic        ula_ovf_q, ula_ovf_d;
  logic [3:0]  defer_q, defer_d;
  logic        cpu_done_q, cpu_done_d;
  logic [13:0] sram_a_q, sram_a_d;
  logic [7:0]  ula_dout_q, ula_dout_d;
  logic        ula_ack_q, ula_ack_d;
  logic [7:0]  cpu_dout_q, cpu_dout_d;

  logic        cpu_req;
  logic        cpu_elig;
  logic        decide;
  logic        enter_ua;
  logic        enter_ca;
  logic [13:0] slot_a;

  always_comb begin
    cpu_req  = ~cpu_mreq_n & (cpu_a[15:14] == 2'b01) & (~cpu_rd_n | ~cpu_wr_n);
    // The slot ending in C_D must not re-grant the same request before cpu_done lands.
    cpu_elig = cpu_req & ~cpu_done_q & (state_q != S_C_D);
    decide   = (state_q == S_IDLE) | (state_q == S_U_D) | (state_q == S_C_D);

    state_d = state_q;
    case (state_q)
      S_U_A:   state_d = S_U_D;
      S_C_A:   state_d = S_C_D;
      default: begin
        if (cpu_elig && (defer_q == C_MAX_DEFER)) state_d = S_C_A;
        else if (ula_pend_q || ula_req)           state_d = S_U_A;
        else if (cpu_elig)                        state_d = S_C_A;
        else                                      state_d = S_IDLE;
      end
    endcase

    enter_ua = (state_d == S_U_A);
    enter_ca = (state_d == S_C_A);
    // A pending fetch is served first; a same-edge request then becomes the new pending one.
    slot_a   = ula_pend_q ? ula_addr_q : ula_va;

    ula_addr_d = ula_req ? ula_va : ula_addr_q;
    ula_pend_d = enter_ua ? (ula_pend_q & ula_req) : (ula_pend_q | ula_req);
    ula_ovf_d  = ula_ovf_q | (ula_req & ula_pend_q & ~enter_ua);

    defer_d = defer_q;
    if (!cpu_req || cpu_done_q || enter_ca) defer_d = 4'd0;
    else if (decide && cpu_elig && enter_ua) defer_d = defer_q + 4'd1;

    cpu_done_d = cpu_done_q;
    if (!cpu_req)                cpu_done_d = 1'b0;
    else if (state_q == S_C_D)   cpu_done_d = 1'b1;

    sram_a_d = sram_a_q;
    if (enter_ua)      sram_a_d = slot_a;
    else if (enter_ca) sram_a_d = cpu_a[13:0];

    ula_ack_d  = (state_q == S_U_D);
    ula_dout_d = (state_q == S_U_D) ? sram_dout : ula_dout_q;
    cpu_dout_d = ((state_q == S_C_D) && !cpu_rd_n) ? sram_dout : cpu_dout_q;
  end

  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ula_addr_q <= 14'd0;
      ula_pend_q <= 1'b0;
      ula_ovf_q  <= 1'b0;
      defer_q    <= 4'd0;
      cpu_done_q <= 1'b0;
      sram_a_q   <= 14'd0;
      ula_dout_q <= 8'd0;
      ula_ack_q  <= 1'b0;
      cpu_dout_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      ula_addr_q <= ula_addr_d;
      ula_pend_q <= ula_pend_d;
      ula_ovf_q  <= ula_ovf_d;
      defer_q    <= defer_d;
      cpu_done_q <= cpu_done_d;
      sram_a_q   <= sram_a_d;
      ula_dout_q <= ula_dout_d;
      ula_ack_q  <= ula_ack_d;
      cpu_dout_q <= cpu_dout_d;
    end
  end

  assign ula_dout   = ula_dout_q;
  assign ula_ack    = ula_ack_q;
  assign ula_ovf    = ula_ovf_q;
  assign cpu_dout   = cpu_dout_q;
  assign sram_a     = sram_a_q;
  assign sram_din   = ((state_q == S_C_A) || (state_q == S_C_D)) ? cpu_din : 8'd0;
  assign sram_we_n  = ~((state_q == S_C_D) & ~cpu_wr_n);
  assign cpu_wait_n = ~rst_n | ~(cpu_req & ~cpu_done_q);

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// tb_vram_arbiter: scoreboard bench for vram_arbiter with a behavioural SRAM
// Revision 1.0
// ============================================================================
module tb_vram_arbiter;

  logic        clk14 = 1'b0;
  logic        rst_n = 1'b0;
  logic        ula_req = 1'b0;
  logic [13:0] ula_va = 14'd0;
  logic [7:0]  ula_dout;
  logic        ula_ack;
  logic        ula_ovf;
  logic [15:0] cpu_a = 16'd0;
  logic        cpu_mreq_n = 1'b1;
  logic        cpu_rd_n = 1'b1;
  logic        cpu_wr_n = 1'b1;
  logic [7:0]  cpu_din = 8'd0;
  logic [7:0]  cpu_dout;
  logic        cpu_wait_n;
  logic [13:0] sram_a;
  logic [7:0]  sram_din;
  logic [7:0]  sram_dout;
  logic        sram_we_n;

  vram_arbiter #(.CPU_MAX_DEFER(4)) dut (
    .clk14(clk14), .rst_n(rst_n),
    .ula_req(ula_req), .ula_va(ula_va), .ula_dout(ula_dout), .ula_ack(ula_ack), .ula_ovf(ula_ovf),
    .cpu_a(cpu_a), .cpu_mreq_n(cpu_mreq_n), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_wait_n(cpu_wait_n),
    .sram_a(sram_a), .sram_din(sram_din), .sram_dout(sram_dout), .sram_we_n(sram_we_n)
  );

  always #5 clk14 = ~clk14;

  logic [7:0] mem [0:16383];
  assign sram_dout = mem[sram_a];
  always @(negedge clk14) if (rst_n && !sram_we_n) mem[sram_a] <= sram_din;

  typedef struct { logic [7:0] data; int cyc; } ula_exp_t;
  typedef struct { int len; bit rd; logic [7:0] data; } cpu_exp_t;
  typedef struct { logic [13:0] a; logic [7:0] d; } wr_exp_t;

  ula_exp_t ula_q[$];
  cpu_exp_t cpu_q[$];
  wr_exp_t  wr_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an ack, write strobe or wait release
  initial begin
    int run;
    ula_exp_t ue;
    cpu_exp_t ce;
    wr_exp_t  we;
    run = 0;
    forever begin
      @(posedge clk14);
      cyc++;
      #1;
      if (ula_ack === 1'b1) begin
        if (ula_q.size() == 0) check("ula_ack_unexpected", 32'(ula_dout), 32'hFFFF_FFFF);
        else begin
          ue = ula_q.pop_front();
          check("ula_dout", 32'(ula_dout), 32'(ue.data));
          check("ula_ack_cycle", 32'(cyc), 32'(ue.cyc));
        end
      end
      if (sram_we_n === 1'b0) begin
        if (wr_q.size() == 0) check("sram_write_unexpected", 32'(sram_a), 32'hFFFF_FFFF);
        else begin
          we = wr_q.pop_front();
          check("sram_a_write", 32'(sram_a), 32'(we.a));
          check("sram_din_write", 32'(sram_din), 32'(we.d));
        end
      end
      if (cpu_wait_n === 1'b0) run++;
      else if (run > 0) begin
        if (cpu_q.size() == 0) check("cpu_wait_unexpected", 32'(run), 32'd0);
        else begin
          ce = cpu_q.pop_front();
          check("cpu_wait_len", 32'(run), 32'(ce.len));
          if (ce.rd) check("cpu_dout", 32'(cpu_dout), 32'(ce.data));
        end
        run = 0;
      end
    end
  end

  task automatic cpu_access(input logic [15:0] a, input bit wr, input logic [7:0] d, input int len);
    cpu_exp_t e;
    bit ok;
    e.len = len; e.rd = !wr; e.data = d;
    cpu_q.push_back(e);
    if (wr) wr_q.push_back('{a[13:0], d});
    cpu_a = a; cpu_din = wr ? d : 8'h00;
    cpu_mreq_n = 1'b0; cpu_rd_n = wr; cpu_wr_n = !wr;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk14);
      if (cpu_wait_n) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL cpu_wait_timeout: got wait_n=0 expected release, addr %0h", a);
    end
    cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
    @(negedge clk14);
  endtask

  // Pulses ula_req at negedge offsets at[i]; ack_at[i] < 0 means the fetch is expected to be lost
  task automatic ula_seq(input int cnt, input int at[6], input logic [13:0] va0,
                         input logic [7:0] d0, input int ack_at[6]);
    int k, t;
    ula_exp_t e;
    k = cyc; t = 0;
    for (int i = 0; i < cnt; i++) begin
      while (t < at[i]) begin
        @(negedge clk14);
        t++;
        ula_req = 1'b0;
      end
      ula_req = 1'b1;
      ula_va  = va0 + 14'(i);
      if (ack_at[i] >= 0) begin
        e.data = d0 + 8'(i);
        e.cyc  = k + ack_at[i];
        ula_q.push_back(e);
      end
    end
    @(negedge clk14);
    ula_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] a_hold;
    // Reset state, with a contended CPU request held to exercise the forced wait release
    cpu_a = 16'h4000; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
    repeat (3) @(negedge clk14);
    check("rst_wait_n_forced", 32'(cpu_wait_n), 32'd1);
    check("rst_sram_a", 32'(sram_a), 32'd0);
    check("rst_sram_we_n", 32'(sram_we_n), 32'd1);
    check("rst_ula_dout", 32'(ula_dout), 32'd0);
    check("rst_ula_ack", 32'(ula_ack), 32'd0);
    check("rst_ula_ovf", 32'(ula_ovf), 32'd0);
    check("rst_cpu_dout", 32'(cpu_dout), 32'd0);
    cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1;
    @(negedge clk14);
    rst_n = 1'b1;
    repeat (2) @(negedge clk14);

    // Preload SRAM through CPU writes (each one also checked)
    cpu_access(16'h5800, 1'b1, 8'hA5, 2);
    for (int i = 0; i < 5; i++) cpu_access(16'h4100 + 16'(i), 1'b1, 8'h11 + 8'(i), 2);
    for (int i = 0; i < 6; i++) cpu_access(16'h4200 + 16'(i), 1'b1, 8'h21 + 8'(i), 2);

    // CPU write then read back
    cpu_access(16'h4123, 1'b1, 8'h3C, 2);
    cpu_access(16'h4123, 1'b0, 8'h3C, 2);

    // ULA-only fetch
    ula_seq(1, '{0, 0, 0, 0, 0, 0}, 14'h1800, 8'hA5, '{3, 0, 0, 0, 0, 0});
    repeat (4) @(negedge clk14);

    // Collision from IDLE: ULA slot first, CPU waits 4 cycles
    fork
      ula_seq(1, '{0, 0, 0, 0, 0, 0}, 14'h0101, 8'h12, '{3, 0, 0, 0, 0, 0});
      cpu_access(16'h4123, 1'b0, 8'h3C, 4);
    join
    repeat (4) @(negedge clk14);

    // Fairness: CPU granted after 4 ULA slots, the pulse during its slot follows it
    fork
      ula_seq(5, '{0, 2, 4, 6, 8, 0}, 14'h0100, 8'h11, '{3, 5, 7, 9, 13, 0});
      cpu_access(16'h4100, 1'b0, 8'h11, 10);
    join
    repeat (4) @(negedge clk14);
    check("fair_no_ovf", 32'(ula_ovf), 32'd0);

    // Overrun: two pulses inside the CPU slot, the second address is fetched
    fork
      ula_seq(6, '{0, 2, 4, 6, 8, 9}, 14'h0200, 8'h21, '{3, 5, 7, 9, -1, 13});
      cpu_access(16'h4200, 1'b0, 8'h21, 10);
    join
    repeat (4) @(negedge clk14);
    check("ovr_ovf_set", 32'(ula_ovf), 32'd1);

    // Uncontended page: no wait, no SRAM activity
    a_hold = sram_a;
    cpu_a = 16'h8000; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
    repeat (4) begin
      @(negedge clk14);
      check("unc_wait_n", 32'(cpu_wait_n), 32'd1);
    end
    check("unc_sram_a_held", 32'(sram_a), 32'(a_hold));
    check("unc_sram_we_n", 32'(sram_we_n), 32'd1);
    cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1;
    @(negedge clk14);

    // Reset in the middle of a write
    cpu_q.push_back('{2, 1'b0, 8'h00});
    wr_q.push_back('{14'h0321, 8'h77});
    cpu_a = 16'h4321; cpu_din = 8'h77; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0;
    repeat (2) @(negedge clk14);
    check("midwr_we_n_low", 32'(sram_we_n), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midwr_we_n_abort", 32'(sram_we_n), 32'd1);
    check("midwr_sram_a", 32'(sram_a), 32'd0);
    check("midwr_ula_ovf", 32'(ula_ovf), 32'd0);
    check("midwr_ula_dout", 32'(ula_dout), 32'd0);
    check("midwr_cpu_dout", 32'(cpu_dout), 32'd0);
    check("midwr_ula_ack", 32'(ula_ack), 32'd0);
    check("midwr_wait_n", 32'(cpu_wait_n), 32'd1);
    cpu_mreq_n = 1'b1; cpu_wr_n = 1'b1;
    @(negedge clk14);
    rst_n = 1'b1;
    repeat (4) @(negedge clk14);
    check("post_rst_idle_sram_a", 32'(sram_a), 32'd0);
    check("post_rst_idle_we_n", 32'(sram_we_n), 32'd1);
    check("post_rst_idle_wait_n", 32'(cpu_wait_n), 32'd1);

    repeat (4) @(negedge clk14);
    check("ula_q_drained", 32'(ula_q.size()), 32'd0);
    check("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
    check("wr_q_drained", 32'(wr_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
